// File: rtl/alu_rr_sequencer_pkg.sv
// Shared definitions for the ALU round-robin sequencer slice.
//   - default operand / function-select widths
//   - function code of the multiplier path
//   - sequencer FSM state type
//   - two-way round-robin pick helper used by rr_arbiter2
package alu_rr_sequencer_pkg;

  localparam int unsigned DATA_W_DEF   = 8;
  localparam int unsigned FSEL_W_DEF   = 4;
  localparam logic [3:0]  MUL_FSEL_DEF = 4'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } seq_state_e;

  // One-hot (or zero) winner between two requesters. A lone requester
  // always wins; on contention the one not granted last time wins.
  function automatic logic [1:0] rr_pick(input logic [1:0] valid,
                                         input logic       last_grant);
    logic [1:0] grant;
    grant = valid;
    if (valid == 2'b11) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end
    return grant;
  endfunction

endpackage

// File: rtl/alu_rr_sequencer_if.sv
// Request/response bus between the two issuing requesters and the ALU
// sequencer.
//   req_valid/req_ready  per-requester handshake, [0] = req0, [1] = req1
//   req_fsel/req_a/req_b {req1, req0} packed function select and operands
//   rsp_valid/rsp_ready  shared response handshake
//   rsp_id               requester owning the response
//   rsp_result/rsp_sreg  {mul_high, reg_out} and status flags of the op
// master: requester/response-consumer side; slave: the sequencer.
interface alu_rr_sequencer_if
  import alu_rr_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned FSEL_W = FSEL_W_DEF
);

  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [2*FSEL_W-1:0] req_fsel;
  logic [2*DATA_W-1:0] req_a;
  logic [2*DATA_W-1:0] req_b;
  logic                rsp_valid;
  logic                rsp_ready;
  logic                rsp_id;
  logic [2*DATA_W-1:0] rsp_result;
  logic [3:0]          rsp_sreg;

  modport master (
    output req_valid, req_fsel, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_sreg
  );

  modport slave (
    input  req_valid, req_fsel, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_sreg
  );

endinterface

// File: rtl/alu_rr_sequencer_rr_arbiter2.sv
// rr_arbiter2: combinational two-way round-robin arbiter.
//   valid[1:0]  requests
//   last_grant  index of the requester granted most recently
//   grant[1:0]  one-hot winner, or zero when nothing is requested
module rr_arbiter2
  import alu_rr_sequencer_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = rr_pick(valid, last_grant);
  end

endmodule

// File: rtl/alu_rr_sequencer.sv
// alu_rr_sequencer: shares one external combinational ALU between two
// requesters. Accepts one op at a time (round-robin), registers the operands
// onto the ALU inputs, waits a function-dependent settle time, captures the
// ALU outputs and returns them on a single valid/ready response channel.
//   clk, rst_n        clock, synchronous active-low reset
//   bus (slave)       request/response channel, see alu_rr_sequencer_if
//   alu_a/alu_b       registered operands to the ALU (held between ops)
//   alu_fsel          registered function select to the ALU
//   alu_res/alu_mulh  ALU reg_out / mul_high
//   alu_sreg          ALU status flags
module alu_rr_sequencer
  import alu_rr_sequencer_pkg::*;
#(
  parameter int unsigned       DATA_W     = DATA_W_DEF,
  parameter int unsigned       FSEL_W     = FSEL_W_DEF,
  parameter int unsigned       ALU_CYCLES = 1,
  parameter int unsigned       MUL_CYCLES = 3,
  parameter logic [FSEL_W-1:0] MUL_FSEL   = FSEL_W'(MUL_FSEL_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_rr_sequencer_if.slave bus,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [FSEL_W-1:0] alu_fsel,
  input  logic [DATA_W-1:0] alu_res,
  input  logic [DATA_W-1:0] alu_mulh,
  input  logic [3:0]        alu_sreg
);

  localparam int unsigned CNT_W = $clog2(MUL_CYCLES + 1);

  seq_state_e          state;
  logic                last_grant;
  logic [1:0]          grant;
  logic [CNT_W-1:0]    cnt;
  logic                g_sel;
  logic [FSEL_W-1:0]   sel_fsel;
  logic [DATA_W-1:0]   sel_a;
  logic [DATA_W-1:0]   sel_b;
  logic                rsp_valid_q;
  logic                rsp_id_q;
  logic [2*DATA_W-1:0] rsp_result_q;
  logic [3:0]          rsp_sreg_q;

  rr_arbiter2 u_arb (
    .valid      (bus.req_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign bus.req_ready  = (state == IDLE) ? grant : 2'b00;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_sreg   = rsp_sreg_q;

  always_comb begin
    g_sel    = grant[1];
    sel_fsel = g_sel ? bus.req_fsel[2*FSEL_W-1 -: FSEL_W] : bus.req_fsel[FSEL_W-1:0];
    sel_a    = g_sel ? bus.req_a[2*DATA_W-1 -: DATA_W]    : bus.req_a[DATA_W-1:0];
    sel_b    = g_sel ? bus.req_b[2*DATA_W-1 -: DATA_W]    : bus.req_b[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      cnt          <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_fsel     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_sreg_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|grant) begin
            alu_a      <= sel_a;
            alu_b      <= sel_b;
            alu_fsel   <= sel_fsel;
            last_grant <= g_sel;
            rsp_id_q   <= g_sel;
            cnt        <= (sel_fsel == MUL_FSEL) ? CNT_W'(MUL_CYCLES) : CNT_W'(ALU_CYCLES);
            state      <= EXEC;
          end
        end
        EXEC: begin
          cnt <= cnt - 1'b1;
          // Last settle cycle: the ALU outputs are final, sample them now.
          if (cnt == CNT_W'(1)) begin
            rsp_result_q <= {alu_mulh, alu_res};
            rsp_sreg_q   <= alu_sreg;
            rsp_valid_q  <= 1'b1;
            state        <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_rr_sequencer.sv
// Self-checking bench for alu_rr_sequencer with a behavioural ALU stub.
// The reference model works at transaction level: an accepted op in cycle t
// owes its response from cycle t+N+1 until the response handshake, and the
// sequencer is free again the cycle after that handshake.
module tb_alu_rr_sequencer;

  localparam int unsigned DW    = 8;
  localparam int unsigned FW    = 4;
  localparam int unsigned ALU_N = 1;
  localparam int unsigned MUL_N = 3;
  localparam logic [FW-1:0] MUL_CODE = 4'd3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] alu_a, alu_b, alu_res, alu_mulh;
  logic [FW-1:0] alu_fsel;
  logic [3:0]    alu_sreg;

  alu_rr_sequencer_if #(.DATA_W(DW), .FSEL_W(FW)) bus ();

  alu_rr_sequencer #(
    .DATA_W     (DW),
    .FSEL_W     (FW),
    .ALU_CYCLES (ALU_N),
    .MUL_CYCLES (MUL_N),
    .MUL_FSEL   (MUL_CODE)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_fsel (alu_fsel),
    .alu_res  (alu_res),
    .alu_mulh (alu_mulh),
    .alu_sreg (alu_sreg)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: returns {sreg, mul_high, reg_out}.
  function automatic logic [2*DW+3:0] alu_fn(input logic [FW-1:0] f,
                                             input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
    logic [2*DW-1:0] w;
    logic [3:0]      s;
    case (f)
      4'd0:    w = {8'd0, a} + {8'd0, b};
      4'd1:    w = {8'd0, a} - {8'd0, b};
      4'd2:    w = {8'd0, a & b};
      4'd3:    w = 16'(a) * 16'(b);
      4'd4:    w = {8'd0, a | b};
      4'd5:    w = {8'd0, a ^ b};
      default: w = {b, a};
    endcase
    s = {w[DW-1], (w[DW-1:0] == 8'd0), |w[2*DW-1:DW], ^w};
    return {s, w};
  endfunction

  always_comb {alu_sreg, alu_mulh, alu_res} = alu_fn(alu_fsel, alu_a, alu_b);

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Pending op per requester, held stable until it is accepted.
  logic [FW-1:0] op_f [2];
  logic [DW-1:0] op_a [2];
  logic [DW-1:0] op_b [2];

  // Reference model state.
  int unsigned   cyc = 0;
  bit            chk_on = 1'b0;
  bit            outst;
  int unsigned   due;
  bit            last_g;
  bit            any_acc;
  logic [FW-1:0] cur_f;
  logic [DW-1:0] cur_a, cur_b;
  logic          exp_id;
  logic [15:0]   exp_res;
  logic [3:0]    exp_sreg;
  bit            acc_g [$];
  int unsigned   acc_c [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic new_op(input int i);
    op_f[i] = ($urandom_range(3) == 0) ? MUL_CODE : FW'($urandom_range(15));
    op_a[i] = DW'($urandom);
    op_b[i] = DW'($urandom);
  endtask

  task automatic model_reset();
    outst    = 1'b0;
    due      = 0;
    last_g   = 1'b1;
    any_acc  = 1'b0;
    cur_f    = '0;
    cur_a    = '0;
    cur_b    = '0;
    exp_id   = 1'b0;
    exp_res  = '0;
    exp_sreg = '0;
  endtask

  function automatic logic [1:0] exp_ready_f(input logic [1:0] v);
    if (outst) return 2'b00;
    if (v == 2'b11) return last_g ? 2'b01 : 2'b10;
    return v;
  endfunction

  function automatic int unsigned settle(input logic [FW-1:0] f);
    return (f == MUL_CODE) ? MUL_N : ALU_N;
  endfunction

  // One clock cycle: drive at the falling edge, check, then advance the model
  // with what the rising edge does.
  task automatic step(input logic [1:0] v, input logic rr, input logic rst_v);
    logic [1:0] er;
    bit         rv;
    bit         g;
    rst_n         = rst_v;
    bus.req_valid = v;
    bus.rsp_ready = rr;
    bus.req_fsel  = {op_f[1], op_f[0]};
    bus.req_a     = {op_a[1], op_a[0]};
    bus.req_b     = {op_b[1], op_b[0]};
    #1;
    er = exp_ready_f(v);
    rv = outst && (cyc >= due);
    if (chk_on) begin
      check("req_ready",  32'(bus.req_ready),  32'(er));
      check("rsp_valid",  32'(bus.rsp_valid),  32'(rv));
      check("rsp_id",     32'(bus.rsp_id),     32'(exp_id));
      check("rsp_result", 32'(bus.rsp_result), 32'(exp_res));
      check("rsp_sreg",   32'(bus.rsp_sreg),   32'(exp_sreg));
      check("alu_a",      32'(alu_a),          any_acc ? 32'(cur_a) : 32'd0);
      check("alu_b",      32'(alu_b),          any_acc ? 32'(cur_b) : 32'd0);
      check("alu_fsel",   32'(alu_fsel),       any_acc ? 32'(cur_f) : 32'd0);
    end
    @(posedge clk);
    if (!rst_v) begin
      model_reset();
    end else begin
      if (rv && rr) begin
        outst = 1'b0;
      end else if (er != 2'b00) begin
        g       = er[1];
        cur_f   = op_f[g];
        cur_a   = op_a[g];
        cur_b   = op_b[g];
        last_g  = g;
        exp_id  = g;
        any_acc = 1'b1;
        outst   = 1'b1;
        due     = cyc + 1 + settle(cur_f);
        acc_g.push_back(g);
        acc_c.push_back(cyc);
        new_op(int'(g));
      end
      if (outst && (cyc + 1 == due)) {exp_sreg, exp_res} = alu_fn(cur_f, cur_a, cur_b);
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && outst; k++) step(2'b00, 1'b1, 1'b1);
    check("drain_idle", 32'(outst), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned n;
    logic [1:0]  v;
    new_op(0);
    new_op(1);
    model_reset();
    @(negedge clk);
    step(2'b00, 1'b0, 1'b0);
    chk_on = 1'b1;
    step(2'b00, 1'b0, 1'b0);

    // 1: single req0 op, one settle cycle.
    op_f[0] = 4'd1; op_a[0] = 8'd6; op_b[0] = 8'd9;
    step(2'b01, 1'b0, 1'b1);
    check("t1_alu_fsel", 32'(alu_fsel), 32'd1);
    check("t1_rsp_early", 32'(bus.rsp_valid), 32'd0);
    step(2'b00, 1'b0, 1'b1);
    check("t1_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("t1_rsp_id", 32'(bus.rsp_id), 32'd0);
    check("t1_result", 32'(bus.rsp_result), 32'h0000_FFFD);
    step(2'b00, 1'b1, 1'b1);

    // 2: both requesting from reset, grants alternate starting with req0.
    step(2'b00, 1'b0, 1'b0);
    step(2'b00, 1'b0, 1'b0);
    acc_g.delete(); acc_c.delete();
    for (int k = 0; k < 200 && acc_g.size() < 8; k++) step(2'b11, 1'b1, 1'b1);
    check("t2_count", 32'(acc_g.size()), 32'd8);
    for (int i = 0; i < acc_g.size(); i++) check("t2_grant", 32'(acc_g[i]), 32'(i % 2));
    drain();

    // 3: req1 multiply, three settle cycles.
    op_f[1] = MUL_CODE; op_a[1] = 8'd127; op_b[1] = 8'd125;
    step(2'b10, 1'b0, 1'b1);
    step(2'b00, 1'b0, 1'b1);
    step(2'b00, 1'b0, 1'b1);
    check("t3_rsp_early", 32'(bus.rsp_valid), 32'd0);
    step(2'b00, 1'b0, 1'b1);
    check("t3_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("t3_result", 32'(bus.rsp_result), 32'h0000_3E03);
    check("t3_rsp_id", 32'(bus.rsp_id), 32'd1);

    // 4: response back-pressure with req0 queued behind it.
    op_f[0] = 4'd2;
    n = acc_g.size();
    for (int k = 0; k < 5; k++) step(2'b01, 1'b0, 1'b1);
    check("t4_hold_valid", 32'(bus.rsp_valid), 32'd1);
    check("t4_hold_result", 32'(bus.rsp_result), 32'h0000_3E03);
    check("t4_hold_id", 32'(bus.rsp_id), 32'd1);
    step(2'b01, 1'b1, 1'b1);
    check("t4_no_early_acc", 32'(acc_g.size()), 32'(n));
    check("t4_rsp_dropped", 32'(bus.rsp_valid), 32'd0);
    step(2'b01, 1'b1, 1'b1);
    check("t4_acc_after_hs", 32'(acc_g.size()), 32'(n + 1));
    drain();

    // 5: reset while executing a multiply.
    op_f[0] = MUL_CODE;
    step(2'b01, 1'b0, 1'b1);
    step(2'b00, 1'b0, 1'b1);
    step(2'b00, 1'b0, 1'b0);
    check("t5_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("t5_alu_a", 32'(alu_a), 32'd0);
    check("t5_alu_b", 32'(alu_b), 32'd0);
    check("t5_alu_fsel", 32'(alu_fsel), 32'd0);
    check("t5_result", 32'(bus.rsp_result), 32'd0);
    check("t5_sreg", 32'(bus.rsp_sreg), 32'd0);
    check("t5_id", 32'(bus.rsp_id), 32'd0);
    check("t5_req_ready", 32'(bus.req_ready), 32'd0);
    acc_g.delete(); acc_c.delete();
    for (int k = 0; k < 20 && acc_g.size() < 1; k++) step(2'b11, 1'b1, 1'b1);
    check("t5_first_grant", (acc_g.size() > 0) ? 32'(acc_g[0]) : 32'hDEAD, 32'd0);
    drain();

    // 6: back-to-back req0 non-multiply ops.
    acc_g.delete(); acc_c.delete();
    if (op_f[0] == MUL_CODE) op_f[0] = 4'd4;
    for (int k = 0; k < 100 && acc_g.size() < 4; k++) begin
      step(2'b01, 1'b1, 1'b1);
      if (op_f[0] == MUL_CODE) op_f[0] = 4'd4;
    end
    check("t6_count", 32'(acc_g.size()), 32'd4);
    for (int i = 1; i < acc_c.size(); i++)
      check("t6_spacing", 32'(acc_c[i] - acc_c[i-1]), 32'(ALU_N + 2));
    drain();

    // Random traffic, back-pressure and occasional resets.
    for (int k = 0; k < 1500; k++) begin
      v = 2'($urandom);
      for (int i = 0; i < 2; i++)
        if (!v[i] && $urandom_range(3) == 0) new_op(i);
      if ($urandom_range(199) == 0) step(2'b00, 1'b0, 1'b0);
      else step(v, ($urandom_range(9) < 7), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
